regfile_wb_ctrl: RTL



---
 rtl/regfile_wb_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_ctrl
// Description : Write-back initiator for the 16-bit CPU register file.
//               Two producers (ALU, load unit) hand results over valid/ready.
//               Accepted results are buffered in a small FIFO, and the FIFO
//               drains one register write per cycle through a registered
//               output stage. A per-register pending scoreboard lets the issue
//               stage stall on read-after-write hazards.
//
// Ports       : clock, reset_n            - clock, async active-low reset
//               alu_valid/rd/data/ready   - ALU result handshake
//               ld_valid/rd/data/ready    - load result handshake
//               RD, WriteData, RegWrite   - registered register-file write port
//               pending[7:0]              - register r has a write in flight
//               fwd_rs, fwd_hit, fwd_data - youngest in-flight value lookup
//
// Parameters  : DEPTH   - FIFO entries (power of two, 2..16)
//               DROP_R0 - 1: results for register 0 are accepted, then dropped
//
// Option      : REGWB_FORWARD_EN - when defined, fwd_hit/fwd_data report the
//               youngest in-flight value for fwd_rs; otherwise both tie to 0.
//
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_ctrl #(
    parameter int DEPTH   = 4,
    parameter int DROP_R0 = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        alu_valid,
    input  logic [2:0]  alu_rd,
    input  logic [15:0] alu_data,
    output logic        alu_ready,
    input  logic        ld_valid,
    input  logic [2:0]  ld_rd,
    input  logic [15:0] ld_data,
    output logic        ld_ready,
    output logic [2:0]  RD,
    output logic [15:0] WriteData,
    output logic        RegWrite,
    output logic [7:0]  pending,
    input  logic [2:0]  fwd_rs,
    output logic        fwd_hit,
    output logic [15:0] fwd_data
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    // FIFO storage (not reset: validity is carried by the count)
    logic [2:0]      r_mem_rd   [DEPTH];
    logic [15:0]     r_mem_data [DEPTH];

    logic [c_AW-1:0] r_wptr_q, r_wptr_d;
    logic [c_AW-1:0] r_rptr_q, r_rptr_d;
    logic [c_CW-1:0] r_cnt_q,  r_cnt_d;
    logic            r_prefer_ld_q, r_prefer_ld_d;  // round-robin pointer, 0 = ALU
    logic            r_ov_q,   r_ov_d;              // output stage valid
    logic [2:0]      r_rd_q,   r_rd_d;
    logic [15:0]     r_wd_q,   r_wd_d;

    logic            w_full;
    logic            w_grant_alu;
    logic            w_grant_ld;
    logic [2:0]      w_acc_rd;
    logic [15:0]     w_acc_data;
    logic            w_enq;
    logic            w_pop;

    // ------------------------------------------------------------------
    // Arbitration: a single accept per cycle. A full FIFO refuses both
    // sources even when a pop happens in the same cycle, keeping ready
    // independent of the drain path.
    // ------------------------------------------------------------------
    always_comb begin
        w_full      = (r_cnt_q == c_FULL);
        w_grant_alu = alu_valid && !w_full && (!ld_valid || !r_prefer_ld_q);
        w_grant_ld  = ld_valid  && !w_full && !w_grant_alu;
        w_acc_rd    = w_grant_ld ? ld_rd   : alu_rd;
        w_acc_data  = w_grant_ld ? ld_data : alu_data;
        // Register-0 results still complete their handshake when dropped.
        w_enq       = (w_grant_alu || w_grant_ld) &&
                      !((DROP_R0 != 0) && (w_acc_rd == 3'd0));
        // The output stage takes the head every cycle the FIFO holds data.
        w_pop       = (r_cnt_q != '0);
    end

    assign alu_ready = w_grant_alu;
    assign ld_ready  = w_grant_ld;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        r_wptr_d      = r_wptr_q;
        r_rptr_d      = r_rptr_q;
        r_cnt_d       = r_cnt_q;
        r_prefer_ld_d = r_prefer_ld_q;
        r_ov_d        = w_pop;
        r_rd_d        = r_rd_q;
        r_wd_d        = r_wd_q;

        if (w_enq) begin
            r_wptr_d = r_wptr_q + c_AW'(1);
        end
        if (w_pop) begin
            r_rptr_d = r_rptr_q + c_AW'(1);
            r_rd_d   = r_mem_rd[r_rptr_q];
            r_wd_d   = r_mem_data[r_rptr_q];
        end

        unique case ({w_enq, w_pop})
            2'b10:   r_cnt_d = r_cnt_q + c_CW'(1);
            2'b01:   r_cnt_d = r_cnt_q - c_CW'(1);
            default: r_cnt_d = r_cnt_q;
        endcase

        // Point away from whichever source just won, dropped or not.
        if (w_grant_alu) begin
            r_prefer_ld_d = 1'b1;
        end else if (w_grant_ld) begin
            r_prefer_ld_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr_q      <= '0;
            r_rptr_q      <= '0;
            r_cnt_q       <= '0;
            r_prefer_ld_q <= 1'b0;
            r_ov_q        <= 1'b0;
            r_rd_q        <= '0;
            r_wd_q        <= '0;
        end else begin
            r_wptr_q      <= r_wptr_d;
            r_rptr_q      <= r_rptr_d;
            r_cnt_q       <= r_cnt_d;
            r_prefer_ld_q <= r_prefer_ld_d;
            r_ov_q        <= r_ov_d;
            r_rd_q        <= r_rd_d;
            r_wd_q        <= r_wd_d;
        end
    end

    always_ff @(posedge clock) begin
        if (w_enq) begin
            r_mem_rd[r_wptr_q]   <= w_acc_rd;
            r_mem_data[r_wptr_q] <= w_acc_data;
        end
    end

    // RD/WriteData hold the last issued write while idle.
    assign RD        = r_rd_q;
    assign WriteData = r_wd_q;
    assign RegWrite  = r_ov_q;

    // ------------------------------------------------------------------
    // Pending scoreboard: entries are walked by age from the read pointer;
    // only the first r_cnt_q slots hold live results.
    // ------------------------------------------------------------------
    always_comb begin
        pending = '0;
        if (r_ov_q) begin
            pending[r_rd_q] = 1'b1;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (c_CW'(i) < r_cnt_q) begin
                pending[r_mem_rd[r_rptr_q + c_AW'(i)]] = 1'b1;
            end
        end
    end

`ifdef REGWB_FORWARD_EN
    // Scan oldest to youngest so the youngest match is the one that sticks;
    // the output stage is older than anything still in the FIFO.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (r_ov_q && (r_rd_q == fwd_rs)) begin
            fwd_hit  = 1'b1;
            fwd_data = r_wd_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if ((c_CW'(i) < r_cnt_q) &&
                (r_mem_rd[r_rptr_q + c_AW'(i)] == fwd_rs)) begin
                fwd_hit  = 1'b1;
                fwd_data = r_mem_data[r_rptr_q + c_AW'(i)];
            end
        end
    end
`else
    logic w_unused_fwd_rs;
    assign w_unused_fwd_rs = ^fwd_rs;
    assign fwd_hit         = 1'b0;
    assign fwd_data        = '0;
`endif

endmodule
`default_nettype wire
